mod_multiplier: RTL and testbench

Parametrised iterative modular multiplier computing c = (a × b) mod m for the ECDSA arithmetic datapath. It replaces the plain registered product, which neither reduces nor handshakes. It uses MSB-first interleaved double-and-add reduction, one multiplier bit per clock, behind valid/ready handshakes on both sides. Width is generic, so the same block serves small test fields and full curve-order widths.

---
 rtl/mod_mul_pkg.sv | 19 +
 rtl/mod_mul_step.sv | 31 +++
 rtl/mod_multiplier.sv | 109 ++++++++++
 tb/tb_mod_multiplier.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mod_mul_pkg.sv
// Shared definitions for the iterative modular multiplier.
//   state_t : controller states (IDLE / RUN / DONE)
//   clog2   : bit-counter width for a given operand width (never below 1)
package mod_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mod_mul_step.sv
// One MSB-first double-and-add step of an interleaved modular multiply.
//   r      : current accumulator (r < m), length+1 bits
//   a, m   : multiplicand and modulus
//   b_bit  : current multiplier bit
//   r_next : ((2r mod m) + b_bit*a) mod m, length+1 bits
// Because r < m and a < m, each intermediate stays below 2m, so a single
// conditional subtraction per stage is enough and length+1 bits never overflow.
module mod_mul_step #(
  parameter int length = 16
) (
  input  logic [length:0]   r,
  input  logic [length-1:0] a,
  input  logic [length-1:0] m,
  input  logic              b_bit,
  output logic [length:0]   r_next
);

  logic [length:0] m_ext;
  logic [length:0] t_dbl;
  logic [length:0] t_red;
  logic [length:0] t_add;

  always_comb begin
    m_ext  = {1'b0, m};
    t_dbl  = r << 1;
    t_red  = (t_dbl >= m_ext) ? (t_dbl - m_ext) : t_dbl;
    t_add  = b_bit ? (t_red + {1'b0, a}) : t_red;
    r_next = (t_add >= m_ext) ? (t_add - m_ext) : t_add;
  end

endmodule

// File: rtl/mod_multiplier.sv
// Iterative modular multiplier c = (a * b) mod m, one multiplier bit per clock,
// with valid/ready handshakes on input and output.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, in_ready  : operand handshake (accepted only in IDLE)
//   a, b, m             : multiplicand (< m), multiplier, modulus (>= 1)
//   out_valid, out_ready: result handshake, result held under back-pressure
//   c, err              : result, and flag for an illegal operand set (c = 0)
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one reduction step per clock, MSB of b first
// DONE  | result held until consumed, out_valid high
module mod_multiplier
  import mod_mul_pkg::*;
#(
  parameter int length = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [length-1:0] a,
  input  logic [length-1:0] b,
  input  logic [length-1:0] m,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [length-1:0] c,
  output logic              err
);

  localparam int CW = clog2(length);

  state_t            state;
  logic [length-1:0] a_q;
  logic [length-1:0] b_q;
  logic [length-1:0] m_q;
  logic [length:0]   r_q;
  logic [length:0]   r_next;
  logic [CW-1:0]     cnt;
  logic              out_valid_q;

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_q;

  mod_mul_step #(.length(length)) u_step (
    .r      (r_q),
    .a      (a_q),
    .m      (m_q),
    .b_bit  (b_q[cnt]),
    .r_next (r_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      r_q         <= '0;
      cnt         <= '0;
      c           <= '0;
      err         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
            m_q <= m;
            r_q <= '0;
            cnt <= CW'(length - 1);
            c   <= '0;
            if (m == '0 || a >= m) begin
              err   <= 1'b1;
              state <= DONE;
            end else begin
              err   <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          r_q <= r_next;
          if (cnt == '0) begin
            c           <= r_next[length-1:0];
            err         <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          // An illegal set enters DONE directly from IDLE; out_valid follows
          // one edge later so the error path still has a one-cycle latency.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_multiplier.sv
module tb_mod_multiplier;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [15:0] a, b, m, c;

  logic        in_valid64, in_ready64, out_valid64, out_ready64, err64;
  logic [63:0] a64, b64, m64, c64;

  int checks;
  int errors;

  mod_multiplier #(.length(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .m(m),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .err(err)
  );

  mod_multiplier #(.length(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .a(a64), .b(b64), .m(m64),
    .out_valid(out_valid64), .out_ready(out_ready64),
    .c(c64), .err(err64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] m;
    logic [15:0] c;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic [15:0] tm,
                       output logic [15:0] rc, output logic re, output int lat);
    in_valid = 1'b1; a = ta; b = tb; m = tm;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); m = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    rc = c; re = err;
  endtask

  task automatic consume16();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run64(input logic [63:0] ta, input logic [63:0] tb, input logic [63:0] tm,
                       output logic [63:0] rc, output int lat);
    in_valid64 = 1'b1; a64 = ta; b64 = tb; m64 = tm;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    a64 = '0; b64 = '0; m64 = '0;
    lat = 0;
    while (!out_valid64 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    rc = c64;
    out_ready64 = 1'b1;
    @(posedge clk); #1;
    out_ready64 = 1'b0;
  endtask

  initial begin
    logic [15:0]  rc;
    logic         re;
    int           lat;
    int           ov_seen;
    logic [63:0]  rc64;
    logic [127:0] prod;

    checks = 0; errors = 0;
    vecs[0]  = '{16'd12345, 16'd54321, 16'd65521, 16'd50831, 1'b0, 16};
    vecs[1]  = '{16'd65520, 16'd65535, 16'd65521, 16'd65507, 1'b0, 16};
    vecs[2]  = '{16'd65520, 16'd0,     16'd65521, 16'd0,     1'b0, 16};
    vecs[3]  = '{16'd0,     16'hFFFF,  16'd1,     16'd0,     1'b0, 16};
    vecs[4]  = '{16'd5,     16'd7,     16'd0,     16'd0,     1'b1, 1};
    vecs[5]  = '{16'd100,   16'd3,     16'd100,   16'd0,     1'b1, 1};
    vecs[6]  = '{16'd7,     16'd9,     16'd10,    16'd3,     1'b0, 16};
    vecs[7]  = '{16'd3,     16'hFFFF,  16'd4,     16'd1,     1'b0, 16};
    vecs[8]  = '{16'd1,     16'hFFFF,  16'hFFFF,  16'd0,     1'b0, 16};
    vecs[9]  = '{16'hFFFE,  16'hFFFE,  16'hFFFF,  16'd1,     1'b0, 16};
    vecs[10] = '{16'd123,   16'd456,   16'd1000,  16'd88,    1'b0, 16};
    vecs[11] = '{16'hFFFF,  16'd2,     16'hFFFF,  16'd0,     1'b1, 1};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; m = '0;
    in_valid64 = 1'b0; out_ready64 = 1'b0; a64 = '0; b64 = '0; m64 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_c", c, 0);
    chk("reset_err", err, 0);

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
      run16(vecs[i].a, vecs[i].b, vecs[i].m, rc, re, lat);
      chk($sformatf("vec%0d_c", i), rc, vecs[i].c);
      chk($sformatf("vec%0d_err", i), re, vecs[i].err);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      consume16();
      chk($sformatf("vec%0d_out_valid_drop", i), out_valid, 0);
      chk($sformatf("vec%0d_in_ready_back", i), in_ready, 1);
    end

    // Back-pressure: result held, inputs ignored
    run16(16'd7, 16'd9, 16'd10, rc, re, lat);
    chk("bp_c_initial", rc, 3);
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      a = 16'($urandom); b = 16'($urandom); m = 16'($urandom);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_c", k), c, 3);
      chk($sformatf("bp%0d_err", k), err, 0);
      chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
      chk($sformatf("bp%0d_out_valid", k), out_valid, 1);
    end
    in_valid = 1'b0;
    consume16();
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    run16(16'd12345, 16'd54321, 16'd65521, rc, re, lat);
    chk("bp_next_c", rc, 50831);
    chk("bp_next_latency", lat, 16);
    consume16();

    // Reset in the middle of RUN
    in_valid = 1'b1; a = 16'd12345; b = 16'd54321; m = 16'd65521;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_c", c, 0);
    chk("midreset_err", err, 0);
    ov_seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    chk("midreset_no_out_valid", ov_seen, 0);
    run16(16'd65520, 16'd65535, 16'd65521, rc, re, lat);
    chk("midreset_fresh_c", rc, 65507);
    chk("midreset_fresh_latency", lat, 16);
    consume16();

    // Random legal operands, width 16
    for (int n = 0; n < 500; n++) begin
      logic [15:0] tm, ta, tb;
      logic [31:0] p;
      tm = 16'($urandom_range(1, 65535));
      ta = 16'($urandom % {16'd0, tm});
      tb = 16'($urandom);
      p  = {16'd0, ta} * {16'd0, tb};
      run16(ta, tb, tm, rc, re, lat);
      chk($sformatf("rnd16_%0d_c", n), rc, 64'(p % {16'd0, tm}));
      chk($sformatf("rnd16_%0d_latency", n), lat, 16);
      consume16();
    end

    // Random legal operands, width 64
    for (int n = 0; n < 500; n++) begin
      logic [63:0] tm, ta, tb;
      tm = {$urandom, $urandom};
      if (tm == '0) tm = 64'd1;
      ta = {$urandom, $urandom} % tm;
      tb = {$urandom, $urandom};
      prod = {64'd0, ta} * {64'd0, tb};
      prod = prod % {64'd0, tm};
      run64(ta, tb, tm, rc64, lat);
      chk($sformatf("rnd64_%0d_c", n), rc64, prod[63:0]);
      chk($sformatf("rnd64_%0d_latency", n), lat, 64);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
